// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control sequencer: FETCH/DECODE/EXEC/MEM/WB over one shared
// req/ack memory port, with traps on illegal opcodes and memory timeouts.
module multicycle_control #(
  parameter int INSTR_LEN   = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INSTR_LEN-1:0] instruction,
  input  logic                 zero,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic                 reg2loc,
  output logic                 alu_src,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic [1:0]           alu_op,
  output logic                 instr_retired,
  output logic [CNT_W-1:0]     retired_count,
  output logic                 trap,
  output logic [1:0]           trap_cause
);

  // Wait counter only has to reach MEM_TIMEOUT-1 before the trap decision.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE, C_LDUR, C_STUR, C_CBZ, C_B
  } iclass_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } cause_t;

  state_t            state_q, state_d;
  iclass_t           iclass_q, dec_class;
  cause_t            cause_q, cause_d;
  logic [WAIT_W-1:0] wait_q;
  logic [CNT_W-1:0]  retired_q;
  logic              dec_legal;
  logic              limit_hit;
  logic [10:0]       opcode;

  logic req, we, addr_sel, irw, pcw, r2l, asrc, m2r, rw, retire;
  logic [1:0] pcs, aop;

  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction;

  assign opcode    = instruction[31:21];
  assign limit_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LIMIT);

  always_comb begin
    dec_class = C_RTYPE;
    dec_legal = 1'b1;
    casez (opcode)
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: dec_class = C_RTYPE;
      11'b11111000010: dec_class = C_LDUR;
      11'b11111000000: dec_class = C_STUR;
      11'b10110100???: dec_class = C_CBZ;
      11'b000101?????: dec_class = C_B;
      default:         dec_legal = 1'b0;
    endcase
  end

  // NOTE: every signal written here gets a default first so no path leaves a latch.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    req      = 1'b0;
    we       = 1'b0;
    addr_sel = 1'b0;
    irw      = 1'b0;
    pcw      = 1'b0;
    pcs      = 2'b00;
    r2l      = 1'b0;
    asrc     = 1'b0;
    m2r      = 1'b0;
    rw       = 1'b0;
    aop      = 2'b00;
    retire   = 1'b0;

    case (state_q)
      S_FETCH: begin
        req = 1'b1;
        if (mem_ack) begin
          irw     = 1'b1;
          state_d = S_DECODE;
        end else if (limit_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        case (iclass_q)
          C_RTYPE: state_d = S_WB;
          C_LDUR, C_STUR: state_d = S_MEM;
          C_CBZ: begin
            pcw     = 1'b1;
            pcs     = zero ? 2'b01 : 2'b00;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          default: begin
            pcw     = 1'b1;
            pcs     = 2'b10;
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        req      = 1'b1;
        addr_sel = 1'b1;
        we       = (iclass_q == C_STUR);
        if (mem_ack) begin
          if (iclass_q == C_STUR) begin
            pcw     = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (limit_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_WB: begin
        rw      = 1'b1;
        m2r     = (iclass_q == C_LDUR);
        pcw     = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // Datapath selects are set in EXEC and held for the rest of the instruction.
    if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
      case (iclass_q)
        C_RTYPE: aop = 2'b10;
        C_LDUR:  asrc = 1'b1;
        C_STUR: begin
          asrc = 1'b1;
          r2l  = 1'b1;
        end
        C_CBZ: begin
          aop = 2'b01;
          r2l = 1'b1;
        end
        default: aop = 2'b00;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      iclass_q  <= C_RTYPE;
      cause_q   <= CAUSE_NONE;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (state_q == S_DECODE) iclass_q <= dec_class;
      wait_q <= (req && !mem_ack) ? wait_q + WAIT_W'(1) : '0;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Outputs are forced low while reset is held, aborting any in-flight access.
  assign mem_req       = rst_n & req;
  assign mem_we        = rst_n & we;
  assign mem_addr_sel  = rst_n & addr_sel;
  assign ir_write      = rst_n & irw;
  assign pc_write      = rst_n & pcw;
  assign pc_src        = rst_n ? pcs : 2'b00;
  assign reg2loc       = rst_n & r2l;
  assign alu_src       = rst_n & asrc;
  assign mem_to_reg    = rst_n & m2r;
  assign reg_write     = rst_n & rw;
  assign alu_op        = rst_n ? aop : 2'b00;
  assign instr_retired = rst_n & retire;
  assign retired_count = rst_n ? retired_q : '0;
  assign trap          = rst_n & (state_q == S_TRAP);
  assign trap_cause    = rst_n ? cause_q : 2'b00;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle sequencer for the LEGv8 datapath: steps each instruction through FETCH/DECODE/EXEC/MEM/WB over one shared memory port with a req/ack handshake. Drives the same control set as the single-cycle decoder (Reg2Loc, ALUSrc, MemtoReg, RegWrite, ALUOp, branch select) plus PC/IR write enables and memory strobes. Supports ADD, SUB, AND, ORR, LDUR, STUR, CBZ and B. Traps on illegal opcodes and on memory timeouts.

Parameters:
INSTR_LEN, 32, instruction width; opcode is instruction[31:21]
MEM_TIMEOUT, 255, max wait cycles for mem_ack before trap; 0 = no timeout
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
instruction  in  INSTR_LEN  IR output; valid from DECODE onward
zero  in  1  ALU zero flag; valid in EXEC
mem_ack  in  1  memory completion; sampled only while mem_req=1
mem_req  out  1  memory access request
mem_we  out  1  1 = write (STUR data phase)
mem_addr_sel  out  1  0 = PC, 1 = ALU result
ir_write  out  1  load IR
pc_write  out  1  load PC
pc_src  out  2  00 = PC+4, 01 = CBZ target, 10 = B target
reg2loc, alu_src, mem_to_reg, reg_write  out  1 each  datapath selects/enables, same meaning as decoder
alu_op  out  2  00 add, 01 pass/compare, 10 R-type funct
instr_retired  out  1  one-cycle pulse per completed instruction
retired_count  out  CNT_W  completed-instruction count
trap  out  1  sticky; controller halted
trap_cause  out  2  01 illegal opcode, 10 memory timeout

Behaviour:
- rst_n low at a clk edge: state <= FETCH, wait counter <= 0, retired_count <= 0, trap and trap_cause <= 0. While rst_n is low, all outputs are 0. Reset mid-access aborts it; mem_req drops in the reset cycle.
- Moore-style outputs decoded from state. Exceptions: ir_write follows mem_ack in FETCH; pc_src follows zero in EXEC for CBZ.
- FETCH: mem_req=1, mem_addr_sel=0. On mem_ack: ir_write=1, go to DECODE. A same-cycle ack is allowed, giving a 1-cycle fetch.
- DECODE (1 cycle): register the opcode class using casex on instruction[31:21].
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000, CBZ 10110100xxx, B 000101xxxxx.
  - Any other opcode: go to TRAP with cause 01.
  - Otherwise go to EXEC.
- EXEC (1 cycle): drive alu_src, reg2loc and alu_op per class. These values stay constant through MEM/WB of the same instruction.
  - R-type: alu_op=10, alu_src=0. Go to WB.
  - LDUR, STUR: alu_op=00, alu_src=1. STUR also sets reg2loc=1. Go to MEM.
  - CBZ: reg2loc=1, alu_op=01. Assert pc_write and instr_retired. pc_src=01 if zero else 00. Go to FETCH.
  - B: pc_write=1, pc_src=10, instr_retired=1. Go to FETCH.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STUR only.
  - On ack, LDUR goes to WB.
  - On ack, STUR asserts pc_write (pc_src=00) and instr_retired, then goes to FETCH.
- WB (1 cycle): reg_write=1, mem_to_reg=1 for LDUR, pc_write=1, pc_src=00, instr_retired=1. Go to FETCH.
- Latency with zero-wait memory: R-type 4 cycles, LDUR 5, STUR 4, CBZ 3, B 3. Each ack wait cycle adds 1.
- Timeout: the wait counter clears on entry to FETCH/MEM. It increments each cycle mem_req=1 and mem_ack=0. When the counter equals MEM_TIMEOUT (nonzero) with no ack: go to TRAP with cause 10 and drop mem_req. An ack on the same cycle the limit is reached wins.
- TRAP: all strobes 0, trap=1, trap_cause held. Exit only via reset.
- retired_count increments on each instr_retired. Wraps modulo 2^CNT_W with no saturation.
- mem_ack while mem_req=0 is ignored.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles during a pending fetch -> all outputs 0; the first cycle after release has mem_req=1, mem_addr_sel=0.
- ADD (0x8B020020) with zero-wait ack -> ir_write in cycle 1; reg_write, pc_write, pc_src=00 and instr_retired in cycle 4; retired_count=1.
- LDUR with 3-cycle MEM ack delay -> mem_req with addr_sel=1 held 3 cycles; WB asserts reg_write+mem_to_reg; total 8 cycles.
- CBZ with zero=1 then zero=0 -> pc_src=01 then 00 in EXEC, both 3 cycles; B -> pc_src=10.
- Opcode 0x000 -> trap=1, trap_cause=01 after DECODE; no further mem_req until reset.
- MEM_TIMEOUT=4, no ack in FETCH -> trap_cause=10 at the 4th wait cycle. Ack arriving on exactly that cycle -> normal DECODE, no trap.
